// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit hex driver for common-anode 7-segment displays.
//
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   value_in     - hex nibbles, nibble i shown on digit i (digit 0 rightmost)
//   dp_in        - decimal point request per digit
//   blank_in     - force digit dark, including its decimal point
//   load         - single-cycle capture strobe for value_in/dp_in/blank_in
//   lz_blank     - leading-zero suppression enable, sampled live
//   seg_out      - segments a..g on bits 6..0
//   dp_out       - decimal point segment
//   an_out       - anode enables, one active outside reset
//   digit_idx    - digit currently being scanned
//   frame_tick   - one-cycle pulse after each frame boundary
//
// New data is held in a pending register and only moved to the displayed
// register at a frame boundary, so a frame never mixes old and new digits.

module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter bit          ACTIVE_LOW  = 1'b1,
    localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    lz_blank,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int unsigned      DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic                    div_wrap;
    logic                    frame_edge;

    logic [4*NUM_DIGITS-1:0] pend_value;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_blank;
    logic                    pend_valid;

    logic [4*NUM_DIGITS-1:0] disp_value;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_blank;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [3:0]              sel_nib;
    logic                    sel_dp;
    logic                    sel_blank;
    logic                    sel_lz;
    logic                    dark;
    logic [NUM_DIGITS-1:0]   an_act;
    logic [6:0]              seg_act;
    logic                    dp_act;

    // Glyph in active-low form (0 = segment lit), bit6 = a .. bit0 = g.
    function automatic logic [6:0] glyph_al(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0001100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    assign div_wrap   = (div_cnt == DIV_LAST);
    assign frame_edge = div_wrap && (digit_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_blank <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_edge;
            if (load) begin
                pend_value <= value_in;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            if (frame_edge) begin
                pend_valid <= 1'b0;
                // A load on the boundary itself bypasses pending so it shows this frame.
                if (load) begin
                    disp_value <= value_in;
                    disp_dp    <= dp_in;
                    disp_blank <= blank_in;
                end else if (pend_valid) begin
                    disp_value <= pend_value;
                    disp_dp    <= pend_dp;
                    disp_blank <= pend_blank;
                end
            end else if (load) begin
                pend_valid <= 1'b1;
            end
        end
    end

    // lz_mask[d] is set when nibbles NUM_DIGITS-1..d are all zero; digit 0 never qualifies.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (disp_value[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        sel_nib   = '0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        sel_lz    = 1'b0;
        an_act    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_act[i] = (digit_idx == IDX_W'(i));
            if (digit_idx == IDX_W'(i)) begin
                sel_nib   = disp_value[4*i +: 4];
                sel_dp    = disp_dp[i];
                sel_blank = disp_blank[i];
                sel_lz    = lz_mask[i];
            end
        end
        dark    = sel_blank | (lz_blank & sel_lz);
        seg_act = dark ? 7'h00 : ~glyph_al(sel_nib);
        dp_act  = ~dark & sel_dp;
    end

    // Outputs are built in active-high form, then flipped for active-low boards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_out  <= {NUM_DIGITS{ACTIVE_LOW}};
            seg_out <= {7{ACTIVE_LOW}};
            dp_out  <= ACTIVE_LOW;
        end else begin
            an_out  <= an_act ^ {NUM_DIGITS{ACTIVE_LOW}};
            seg_out <= seg_act ^ {7{ACTIVE_LOW}};
            dp_out  <= dp_act ^ ACTIVE_LOW;
        end
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised, time-multiplexed N-digit hex display driver for the board's common-anode 7-segment displays.
- Scans digits at a programmable refresh rate and latches display data through a tear-free shadow register.
- Supports per-digit decimal points, forced blanking, leading-zero suppression and selectable output polarity.
- Sits between any value producer (counter, debug bus, CPU register) and the display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000: clk cycles each digit is lit; must be >= 2.
- ACTIVE_LOW, 1: 1 = segments and anodes driven low to light; 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value_in  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, with digit 0 the rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_in  in  NUM_DIGITS  force digit i dark, including its decimal point.
- load  in  1  single-cycle pulse; captures value_in, dp_in and blank_in.
- lz_blank  in  1  leading-zero suppression enable; sampled live.
- seg_out  out  7  segments, bit6 = a ... bit0 = g.
- dp_out  out  1  decimal point segment.
- an_out  out  NUM_DIGITS  anode enables; exactly one active outside reset.
- digit_idx  out  max(1,clog2(NUM_DIGITS))  index of the digit currently lit.
- frame_tick  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async, held while rst=1):
  - Divider counter = 0, digit_idx = 0.
  - Pending and displayed registers = all zero; pending_valid = 0; frame_tick = 0.
  - an_out, seg_out and dp_out are all inactive (all 1s when ACTIVE_LOW=1).
- Divider:
  - Counts 0..REFRESH_DIV-1.
  - On wrap, digit_idx increments modulo NUM_DIGITS.
- Frame boundary: the edge where digit_idx wraps from NUM_DIGITS-1 to 0.
  - frame_tick is registered high for exactly the cycle following that edge.
- Load:
  - On load=1, the pending register captures the inputs and pending_valid is set.
  - A later load before the boundary overwrites pending; last wins.
- Displayed register updates only at a frame boundary, so there is no mid-frame tearing:
  - if load=1 on the boundary cycle: displayed <= the inputs directly; pending_valid cleared.
  - else if pending_valid=1: displayed <= pending; pending_valid cleared.
  - else: displayed unchanged.
- Output pipeline:
  - an_out, seg_out and dp_out are registered from digit_idx and the displayed register.
  - Latency is 1 cycle: outputs change on the edge after digit_idx changes.
  - For a selected digit d, the active-level form has only bit d set in an_out, with segments and dp from digit d; ACTIVE_LOW inverts all three outputs.
- Glyphs, listed in ACTIVE_LOW=1 form (abcdefg):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - ACTIVE_LOW=0 drives the bitwise inverse.
- Blanking:
  - A blanked digit keeps its anode active but drives all segments and dp inactive.
  - blank_in[d]=1 blanks digit d.
  - With lz_blank=1, digit d (d>0) is blanked when displayed nibbles NUM_DIGITS-1..d are all zero; its dp is suppressed too.
  - Digit 0 is never leading-zero blanked.
- NUM_DIGITS=1: digit_idx stays 0; frame_tick pulses every REFRESH_DIV cycles.
- Reset mid-scan: outputs go inactive immediately and asynchronously. Scanning restarts at digit 0 with a full REFRESH_DIV period on the first edge after rst falls; any pending load is discarded.

Test Plan:
- REFRESH_DIV=4, NUM_DIGITS=4, reset released, no load:
  - an_out cycles 1110, 1101, 1011, 0111, each held 4 cycles, with seg_out=0000001.
  - frame_tick pulses every 16 cycles.
- Load of value 0x1A3F mid-frame at digit 1:
  - Outputs show 0000 until the next boundary.
  - Then digit 0 = 0111000, digit 1 = 0000110, digit 2 = 0001000, digit 3 = 1001111.
- Two loads in one frame (0x1111, then 0x2222), plus a load of 0x3333 exactly on the boundary cycle:
  - The first displayed value is 0x2222.
  - A load of 0x3333 on the boundary cycle is shown from that frame with no one-frame delay.
- lz_blank=1 with value 0x0042 and dp_in=4'b1000:
  - Digits 3 and 2 are dark, including the dp of digit 3; digits 1 and 0 show 4 and 2.
  - Value 0x0000 shows only digit 0 = 0.
- blank_in=4'b0010 with value 0x8888: digit 1 segments read 1111111 while its anode is still active.
- rst asserted mid-scan at digit 2:
  - an_out=1111 asynchronously.
  - After release, scanning restarts at digit 0 showing 0 and the pending load is lost.
  - Repeat with ACTIVE_LOW=0 and check inverted polarity on all outputs.
